// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each granted access takes three cycles: IDLE (arbitrate), ISSUE (memory strobe), COMPLETE (ack).
module dm_arbiter #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [31:0]   ad0,
    input  logic [31:0]   ad1,
    input  logic [31:0]   wr_data0,
    input  logic [31:0]   wr_data1,
    output logic          ack0,
    output logic          ack1,
    output logic [31:0]   rd_data0,
    output logic [31:0]   rd_data1,
    output logic          err0,
    output logic          err1,
    output logic [AW-1:0] mem_ad,
    output logic [31:0]   mem_wr_data,
    output logic          mem_wr,
    output logic          mem_rd,
    input  logic [31:0]   mem_rd_data,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        COMPLETE
    } state_t;

    state_t      state;
    logic        last;
    logic        win;
    logic        lat_we;
    logic        lat_oor;
    logic        rd_ok0;
    logic        rd_ok1;

    logic        any_req;
    logic        grant;
    logic        sel_we;
    logic [31:0] sel_ad;
    logic [31:0] sel_wd;
    logic        sel_oor;

    // Both requesting: the port that did not win last time goes next.
    always_comb begin
        any_req = req0 | req1;
        grant   = (req0 && req1) ? ~last : req1;
        sel_we  = grant ? we1 : we0;
        sel_ad  = grant ? ad1 : ad0;
        sel_wd  = grant ? wr_data1 : wr_data0;
        sel_oor = |sel_ad[31:AW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= 1'b1;
            win         <= 1'b0;
            lat_we      <= 1'b0;
            lat_oor     <= 1'b0;
            rd_ok0      <= 1'b0;
            rd_ok1      <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            err0        <= 1'b0;
            err1        <= 1'b0;
            mem_ad      <= '0;
            mem_wr_data <= '0;
            mem_wr      <= 1'b0;
            mem_rd      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state       <= ISSUE;
                        last        <= grant;
                        win         <= grant;
                        lat_we      <= sel_we;
                        lat_oor     <= sel_oor;
                        mem_ad      <= sel_ad[AW-1:0];
                        mem_wr_data <= sel_wd;
                        mem_wr      <= sel_we & ~sel_oor;
                        mem_rd      <= ~sel_we & ~sel_oor;
                    end
                end
                ISSUE: begin
                    state  <= COMPLETE;
                    mem_wr <= 1'b0;
                    mem_rd <= 1'b0;
                    ack0   <= ~win;
                    ack1   <= win;
                    err0   <= ~win & lat_oor;
                    err1   <= win & lat_oor;
                    rd_ok0 <= ~win & ~lat_we & ~lat_oor;
                    rd_ok1 <= win & ~lat_we & ~lat_oor;
                end
                COMPLETE: begin
                    state  <= IDLE;
                    ack0   <= 1'b0;
                    ack1   <= 1'b0;
                    err0   <= 1'b0;
                    err1   <= 1'b0;
                    rd_ok0 <= 1'b0;
                    rd_ok1 <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory read data arrives during COMPLETE, so it is steered rather than registered.
    assign rd_data0 = rd_ok0 ? mem_rd_data : 32'h0;
    assign rd_data1 = rd_ok1 ? mem_rd_data : 32'h0;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed scoreboard bench for dm_arbiter with a behavioural 64-word memory attached.
module tb_dm_arbiter;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1, we0, we1;
    logic [31:0]   ad0, ad1, wr_data0, wr_data1;
    logic          ack0, ack1, err0, err1;
    logic [31:0]   rd_data0, rd_data1;
    logic [AW-1:0] mem_ad;
    logic [31:0]   mem_wr_data;
    logic          mem_wr, mem_rd;
    logic [31:0]   mem_rd_data;
    logic          busy;

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] ad;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [0:63];
    logic [31:0] mem [0:63];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .ad0(ad0), .ad1(ad1), .wr_data0(wr_data0), .wr_data1(wr_data1),
        .ack0(ack0), .ack1(ack1), .rd_data0(rd_data0), .rd_data1(rd_data1),
        .err0(err0), .err1(err1),
        .mem_ad(mem_ad), .mem_wr_data(mem_wr_data), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .mem_rd_data(mem_rd_data), .busy(busy)
    );

    // Data memory: write on the strobe edge, read data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_wr) mem[mem_ad] <= mem_wr_data;
        if (mem_rd) mem_rd_data <= mem[mem_ad];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Drive one port's request; optionally record the expected completion in the scoreboard.
    task automatic applyStimulus(input int port, input logic we, input logic [31:0] ad,
                                 input logic [31:0] wd, input bit push);
        exp_t e;
        logic inr;
        if (port == 0) begin
            req0 = 1'b1; we0 = we; ad0 = ad; wr_data0 = wd;
        end else begin
            req1 = 1'b1; we1 = we; ad1 = ad; wr_data1 = wd;
        end
        if (push) begin
            inr     = ((ad >> AW) == 32'h0);
            e.port  = port;
            e.we    = we;
            e.ad    = ad;
            e.wd    = wd;
            e.err   = ~inr;
            if (we && inr) ref_mem[ad[AW-1:0]] = wd;
            e.rdata = (!we && inr) ? ref_mem[ad[AW-1:0]] : 32'h0;
            exp_q.push_back(e);
        end
    endtask

    // Called at the negedge before the granting edge; checks ISSUE, COMPLETE and the following IDLE cycle.
    task automatic runTransaction(input bit drop);
        exp_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = exp_q[0];
        @(negedge clk);
        checkBit("issue_busy", busy, 1'b1);
        checkBit("issue_mem_wr", mem_wr, e.we & ~e.err);
        checkBit("issue_mem_rd", mem_rd, ~e.we & ~e.err);
        checkOutput("issue_mem_ad", 32'(mem_ad), 32'(e.ad[AW-1:0]));
        checkOutput("issue_mem_wr_data", mem_wr_data, e.wd);
        checkBit("issue_ack0", ack0, 1'b0);
        checkBit("issue_ack1", ack1, 1'b0);
        @(negedge clk);
        e = exp_q.pop_front();
        checkBit("complete_ack0", ack0, e.port == 0);
        checkBit("complete_ack1", ack1, e.port == 1);
        checkOutput("complete_rd_data0", rd_data0, (e.port == 0) ? e.rdata : 32'h0);
        checkOutput("complete_rd_data1", rd_data1, (e.port == 1) ? e.rdata : 32'h0);
        checkBit("complete_err0", err0, (e.port == 0) & e.err);
        checkBit("complete_err1", err1, (e.port == 1) & e.err);
        checkBit("complete_mem_wr", mem_wr, 1'b0);
        checkBit("complete_mem_rd", mem_rd, 1'b0);
        if (drop) begin
            if (e.port == 0) req0 = 1'b0;
            else             req1 = 1'b0;
        end
        @(negedge clk);
        checkBit("idle_busy", busy, 1'b0);
        checkBit("idle_ack0", ack0, 1'b0);
        checkBit("idle_ack1", ack1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        ad0 = '0; ad1 = '0; wr_data0 = '0; wr_data1 = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkBit("rst_busy", busy, 1'b0);
        checkBit("rst_ack0", ack0, 1'b0);
        checkBit("rst_ack1", ack1, 1'b0);
        checkBit("rst_err0", err0, 1'b0);
        checkBit("rst_mem_wr", mem_wr, 1'b0);
        checkBit("rst_mem_rd", mem_rd, 1'b0);
        checkOutput("rst_mem_ad", 32'(mem_ad), 32'h0);
        checkOutput("rst_mem_wr_data", mem_wr_data, 32'h0);
        checkOutput("rst_rd_data0", rd_data0, 32'h0);
        rst_n = 1'b1;

        // Single write, read-back on the other port, then both ports out of range.
        applyStimulus(0, 1'b1, 32'd5, 32'hDEADBEEF, 1'b1);
        runTransaction(1'b1);
        applyStimulus(1, 1'b0, 32'd5, 32'h0, 1'b1);
        runTransaction(1'b1);
        applyStimulus(0, 1'b1, 32'd64, 32'h11112222, 1'b1);
        runTransaction(1'b1);
        applyStimulus(1, 1'b0, 32'h100, 32'h0, 1'b1);
        runTransaction(1'b1);

        // Back-to-back on port 0 with a new address right after the ack.
        applyStimulus(0, 1'b1, 32'd7, 32'hA5A50007, 1'b1);
        runTransaction(1'b0);
        applyStimulus(0, 1'b1, 32'd8, 32'h5A5A0008, 1'b1);
        runTransaction(1'b1);
        applyStimulus(1, 1'b0, 32'd7, 32'h0, 1'b1);
        runTransaction(1'b1);
        applyStimulus(1, 1'b0, 32'd8, 32'h0, 1'b1);
        runTransaction(1'b1);

        // Abort a write in ISSUE with reset; nothing may reach memory or the requester.
        applyStimulus(0, 1'b1, 32'd5, 32'h12345678, 1'b0);
        @(negedge clk);
        checkBit("abort_issue_mem_wr", mem_wr, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        checkBit("abort_mem_wr", mem_wr, 1'b0);
        checkBit("abort_busy", busy, 1'b0);
        @(negedge clk);
        checkBit("abort_ack0", ack0, 1'b0);
        req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Contention straight after reset: grants 0,1,0,1.
        applyStimulus(0, 1'b1, 32'd10, 32'hC0DE0001, 1'b1);
        applyStimulus(1, 1'b0, 32'd10, 32'h0, 1'b1);
        runTransaction(1'b0);
        applyStimulus(0, 1'b1, 32'd10, 32'hC0DE0002, 1'b1);
        runTransaction(1'b0);
        applyStimulus(1, 1'b0, 32'd10, 32'h0, 1'b1);
        runTransaction(1'b1);
        runTransaction(1'b1);

        // The aborted write must not have touched word 5.
        applyStimulus(1, 1'b0, 32'd5, 32'h0, 1'b1);
        runTransaction(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
